// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill controller: default widths and FSM states.
package cache_pkg;

  localparam int ADDR_W  = 15;
  localparam int INDEX_W = 12;
  localparam int DATA_W  = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    FILL     = 3'd4,
    RESP     = 3'd5
  } state_t;

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Bundle of request, cache, backing-memory, response and statistics signals
// around the refill controller. master = controller side, slave = environment.
interface cache_refill_ctrl_if #(
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int DATA_W = cache_pkg::DATA_W,
  parameter int CNT_W  = 16
);

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_hit;
  logic [DATA_W-1:0] cache_rdata;
  logic              fill_en;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_hit;
  logic              resp_err;
  logic              resp_ready;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  modport master (
    input  req_valid, req_addr, cache_hit, cache_rdata,
           mem_gnt, mem_rvalid, mem_rdata, resp_ready,
    output req_ready, cache_addr, fill_en, fill_addr, fill_data,
           mem_req, mem_addr, resp_valid, resp_data, resp_hit, resp_err,
           hit_cnt, miss_cnt
  );

  modport slave (
    output req_valid, req_addr, cache_hit, cache_rdata,
           mem_gnt, mem_rvalid, mem_rdata, resp_ready,
    input  req_ready, cache_addr, fill_en, fill_addr, fill_data,
           mem_req, mem_addr, resp_valid, resp_data, resp_hit, resp_err,
           hit_cnt, miss_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping; async clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count one event per cycle, sticking at the maximum value.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Single-outstanding read controller: probes the direct-mapped cache, refills
// it from backing memory on a miss, and aborts a fetch that stalls too long.
module cache_refill_ctrl #(
  parameter int ADDR_W  = cache_pkg::ADDR_W,
  parameter int INDEX_W = cache_pkg::INDEX_W,
  parameter int DATA_W  = cache_pkg::DATA_W,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  cache_refill_ctrl_if.master bus
);

  import cache_pkg::*;

  // Wait counter must be able to hold the value TIMEOUT itself.
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [TW-1:0]     wait_cnt;
  logic              req_ready_r;
  logic              mem_req_r;
  logic              fill_en_r;
  logic              resp_valid_r;
  logic              resp_hit_r;
  logic              resp_err_r;
  logic              hit_inc;
  logic              miss_inc;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  // The lookup cycle is the only place a request is classified; a timed-out
  // fetch has already been counted as a miss here.
  assign hit_inc  = (state == LOOKUP) &&  bus.cache_hit;
  assign miss_inc = (state == LOOKUP) && !bus.cache_hit;

  // Control FSM plus address/data capture; all handshake outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      data         <= '0;
      wait_cnt     <= '0;
      req_ready_r  <= 1'b1;
      mem_req_r    <= 1'b0;
      fill_en_r    <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_hit_r   <= 1'b0;
      resp_err_r   <= 1'b0;
    end else begin
      fill_en_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr        <= bus.req_addr;
            req_ready_r <= 1'b0;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (bus.cache_hit) begin
            data         <= bus.cache_rdata;
            resp_hit_r   <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_valid_r <= 1'b1;
            state        <= RESP;
          end else begin
            mem_req_r <= 1'b1;
            wait_cnt  <= '0;
            state     <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (bus.mem_gnt) begin
            mem_req_r <= 1'b0;
            state     <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          // Returned data takes priority over an abort in the same cycle.
          if (bus.mem_rvalid) begin
            data      <= bus.mem_rdata;
            fill_en_r <= 1'b1;
            state     <= FILL;
          end else if (wait_cnt == TW'(TIMEOUT)) begin
            data         <= '0;
            resp_hit_r   <= 1'b0;
            resp_err_r   <= 1'b1;
            resp_valid_r <= 1'b1;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        FILL: begin
          resp_hit_r   <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_valid_r <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_hit_r   <= 1'b0;
            resp_err_r   <= 1'b0;
            req_ready_r  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

  assign bus.req_ready  = req_ready_r;
  assign bus.cache_addr = addr;
  assign bus.mem_req    = mem_req_r;
  assign bus.mem_addr   = addr;
  assign bus.fill_en    = fill_en_r;
  // Fill location is the latched tag concatenated with the latched index.
  assign bus.fill_addr  = {addr[ADDR_W-1:INDEX_W], addr[INDEX_W-1:0]};
  assign bus.fill_data  = data;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_data  = data;
  assign bus.resp_hit   = resp_hit_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.hit_cnt    = hit_count;
  assign bus.miss_cnt   = miss_count;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed scenarios followed by
// randomized transactions, checked cycle by cycle against a timeline model.
module tb_cache_refill_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_hits;
  int   exp_misses;

  cache_refill_ctrl_if #(.ADDR_W(15), .DATA_W(32), .CNT_W(CNT_W)) bus ();

  cache_refill_ctrl #(
    .ADDR_W  (15),
    .INDEX_W (12),
    .DATA_W  (32),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // mode 0: quiet, 1: random, 2: always asserted (for don't-care inputs)
  function automatic logic noise(input int mode);
    if (mode == 2) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  task automatic drive_idle();
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.cache_hit   = 1'b0;
    bus.cache_rdata = '0;
    bus.mem_gnt     = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;
    bus.resp_ready  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  32'(bus.req_ready), 32'd1);
    check({tag, "_mem_req"},    32'(bus.mem_req), 32'd0);
    check({tag, "_fill_en"},    32'(bus.fill_en), 32'd0);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_resp_data"},  bus.resp_data, 32'd0);
    check({tag, "_resp_hit"},   32'(bus.resp_hit), 32'd0);
    check({tag, "_resp_err"},   32'(bus.resp_err), 32'd0);
    check({tag, "_cache_addr"}, 32'(bus.cache_addr), 32'd0);
    check({tag, "_mem_addr"},   32'(bus.mem_addr), 32'd0);
    check({tag, "_fill_addr"},  32'(bus.fill_addr), 32'd0);
    check({tag, "_fill_data"},  bus.fill_data, 32'd0);
    check({tag, "_hit_cnt"},    32'(bus.hit_cnt), 32'd0);
    check({tag, "_miss_cnt"},   32'(bus.miss_cnt), 32'd0);
  endtask

  // One complete transaction starting in an idle cycle (t=0 is the accept
  // cycle). g = cycles mem_req waits before gnt, r = MEM_WAIT cycle index at
  // which rvalid arrives (r > TIMEOUT means never), d = resp_ready delay.
  task automatic run_txn(input logic [14:0] a, input bit hit, input logic [31:0] crd,
                         input int g, input int r, input logic [31:0] md,
                         input int d, input int mode);
    int tr, tf, tend, hb, mb, ha, ma;
    bit fill, err, in_req, in_wait;
    logic [31:0] exp_data;
    tf = -1;
    if (hit) begin
      tr = 2; fill = 0; err = 0; exp_data = crd;
    end else if (r <= TIMEOUT) begin
      tf = 4 + g + r; tr = tf + 1; fill = 1; err = 0; exp_data = md;
    end else begin
      tr = 4 + g + TIMEOUT; fill = 0; err = 1; exp_data = 32'd0;
    end
    tend = tr + d;
    hb = exp_hits;
    mb = exp_misses;
    ha = hit ? sat_inc(hb) : hb;
    ma = hit ? mb : sat_inc(mb);
    for (int t = 0; t <= tend; t++) begin
      in_req  = !hit && (t >= 2) && (t <= 2 + g);
      in_wait = !hit && (t >= 3 + g) && (t <= 3 + g + ((r <= TIMEOUT) ? r : TIMEOUT));
      bus.req_valid   = (t == 0) ? 1'b1 : noise(mode);
      bus.req_addr    = (t == 0) ? a : 15'($urandom);
      bus.cache_hit   = (t == 1) ? hit : noise(mode);
      bus.cache_rdata = (t == 1) ? crd : $urandom;
      bus.mem_gnt     = in_req ? (t == 2 + g) : noise(mode);
      bus.mem_rvalid  = in_wait ? (t == 3 + g + r) : noise(mode);
      bus.mem_rdata   = (in_wait && (t == 3 + g + r)) ? md : $urandom;
      bus.resp_ready  = (t >= tr) ? (t == tend) : noise(mode);
      @(negedge clk);
      check("req_ready",  32'(bus.req_ready), 32'(t == 0));
      check("mem_req",    32'(bus.mem_req), 32'(in_req));
      check("fill_en",    32'(bus.fill_en), 32'(fill && (t == tf)));
      check("resp_valid", 32'(bus.resp_valid), 32'(t >= tr));
      check("hit_cnt",    32'(bus.hit_cnt), 32'((t >= 2) ? ha : hb));
      check("miss_cnt",   32'(bus.miss_cnt), 32'((t >= 2) ? ma : mb));
      if (t >= 1) check("cache_addr", 32'(bus.cache_addr), 32'(a));
      if (in_req) check("mem_addr", 32'(bus.mem_addr), 32'(a));
      if (fill && (t == tf)) begin
        check("fill_addr", 32'(bus.fill_addr), 32'(a));
        check("fill_data", bus.fill_data, md);
      end
      if (t >= tr) begin
        check("resp_data", bus.resp_data, exp_data);
        check("resp_hit",  32'(bus.resp_hit), 32'(hit));
        check("resp_err",  32'(bus.resp_err), 32'(err));
      end
      @(posedge clk);
      #1;
    end
    exp_hits   = ha;
    exp_misses = ma;
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    checks     = 0;
    errors     = 0;
    exp_hits   = 0;
    exp_misses = 0;
    drive_idle();

    // Reset state, both while held and after release.
    #12;
    check_reset_outputs("reset_held");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_released");
    @(posedge clk);
    #1;

    // Hit: response two cycles after accept, no memory traffic.
    run_txn(15'h1234, 1'b1, 32'hCAFE0001, 0, 0, 32'h0, 0, 0);
    check("hit_cnt_after_hit", 32'(bus.hit_cnt), 32'd1);

    // Miss: gnt after 3 waiting cycles, rvalid on the 5th MEM_WAIT cycle
    // (the same cycle the abort would fire; the data must win).
    run_txn(15'h1234, 1'b0, 32'h0, 3, 4, 32'hDEAD0002, 0, 0);
    check("miss_cnt_after_miss", 32'(bus.miss_cnt), 32'd1);

    // Timeout: no rvalid in the window; late rvalid/gnt held high afterwards.
    run_txn(15'h2A5C, 1'b0, 32'h0, 1, 99, 32'h0BAD0BAD, 2, 2);

    // Backpressure: response held 10 cycles while new requests are offered.
    run_txn(15'h0F0F, 1'b1, 32'h5A5A1234, 0, 0, 32'h0, 10, 2);
    run_txn(15'h7001, 1'b0, 32'h0, 0, 0, 32'h11223344, 10, 2);

    // Reset in the middle of MEM_WAIT drops the fetch and clears counters.
    drive_idle();
    bus.req_valid = 1'b1;
    bus.req_addr  = 15'h0ABC;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.cache_hit = 1'b0;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_miss_cnt", 32'(bus.miss_cnt), 32'(sat_inc(exp_misses)));
    check("pre_rst_mem_addr", 32'(bus.mem_addr), 32'h0ABC);
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_wait");
    exp_hits   = 0;
    exp_misses = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_txn(15'h0321, 1'b1, 32'h600DF00D, 0, 0, 32'h0, 1, 0);

    // Saturation: four more hits (five in total since reset) stick at max.
    for (int i = 0; i < 4; i++)
      run_txn(15'($urandom), 1'b1, $urandom, 0, 0, 32'h0, 0, 1);
    check("hit_cnt_saturated", 32'(bus.hit_cnt), 32'(CNT_MAX));

    // Randomized mix of hits, fills and timeouts with noisy don't-care inputs.
    for (int i = 0; i < 40; i++)
      run_txn(15'($urandom), 1'($urandom_range(0, 1)), $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), $urandom,
              int'($urandom_range(0, 3)), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
